// File: rtl/t5_pkg.sv
// Shared T5 core constants: major opcodes (instr[6:2]) and pipeline sequencer state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package t5_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'h00;
    localparam logic [4:0] OPC_OPIMM  = 5'h04;
    localparam logic [4:0] OPC_STORE  = 5'h08;
    localparam logic [4:0] OPC_BRANCH = 5'h18;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IWAIT = 2'd1,
        ST_DWAIT = 2'd2,
        ST_FLUSH = 2'd3
    } st_t;

endpackage

// File: rtl/t5_pipe_ctrl_if.sv
// Sequencer <-> datapath bundle: fetch handshake, data-bus status, hazard operands, stage controls.
// Latency: n/a (wiring only).
// Backpressure: n/a (wiring only).
// master : the pipeline sequencer (drives ireq/sena/dbub/dflush/sbusy)
// slave  : the datapath / memory side (drives iack, dreq, dack, xbra, opcodes and register indices)
interface t5_pipe_ctrl_if;

    logic       ireq;
    logic       iack;
    logic       dreq;
    logic       dack;
    logic       xbra;
    logic [4:0] dopc;
    logic [4:0] drs1;
    logic [4:0] drs2;
    logic [4:0] xopc;
    logic [4:0] xrd;
    logic       sena;
    logic       dbub;
    logic       dflush;
    logic       sbusy;

    modport master (
        output ireq, sena, dbub, dflush, sbusy,
        input  iack, dreq, dack, xbra, dopc, drs1, drs2, xopc, xrd
    );

    modport slave (
        input  ireq, sena, dbub, dflush, sbusy,
        output iack, dreq, dack, xbra, dopc, drs1, drs2, xopc, xrd
    );

endinterface

// File: rtl/t5_hazard.sv
// Load-use detector: flags a LOAD in execute whose rd feeds either source of the decode instruction.
// Latency: purely combinational, same cycle.
// Backpressure: none; the sequencer turns luse into a one-cycle bubble.
// Ports: xopc/xrd (execute opcode, dest), drs1/drs2 (decode sources) -> luse.
module t5_hazard
    import t5_pkg::*;
(
    input  logic [4:0] xopc,
    input  logic [4:0] xrd,
    input  logic [4:0] drs1,
    input  logic [4:0] drs2,
    output logic       luse
);

    // rs2 is compared even for formats that have no rs2; a spurious bubble costs one
    // cycle, a missed one corrupts data, and it avoids decoding the instruction format.
    assign luse = (xopc == OPC_LOAD) && (xrd != 5'd0) && ((xrd == drs1) || (xrd == drs2));

endmodule

// File: rtl/t5_pipe_ctrl.sv
// T5 pipeline sequencer: global stage enable, fetch request, load-use bubbles and branch flushes.
// Latency: sena/dbub/dflush are combinational from state and inputs; state advances on each sclk.
// Backpressure: data-bus wait (dreq & ~dack) and fetch wait (ireq & ~iack) drop sena until acked.
// Ports: sclk, srst (async active-high), bus (t5_pipe_ctrl_if.master).
// Optional T5_PERFCNT_EN: adds cstl (cycles with sena=0) and cflu (FLUSH entries), XLEN wide.
module t5_pipe_ctrl
    import t5_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int FLUSH_CYC = 2
) (
    input  logic           sclk,
    input  logic           srst,
    t5_pipe_ctrl_if.master bus
`ifdef T5_PERFCNT_EN
    ,
    output logic [XLEN-1:0] cstl,
    output logic [XLEN-1:0] cflu
`endif
);

    localparam logic [1:0] FCNT_LOAD = 2'(FLUSH_CYC - 1);

    st_t        st;
    logic [1:0] fcnt;
    logic       ireq_q;
    logic       bpend;    // branch seen while waiting on the data bus
    logic       ihave;    // fetch data arrived while waiting on the data bus
    logic       luse;
    logic       dstall;
    logic       fwait;
    logic       flu_ent;
    logic       sena;
    logic       dbub;
    logic       dflush;

    t5_hazard u_hazard (
        .xopc (bus.xopc),
        .xrd  (bus.xrd),
        .drs1 (bus.drs1),
        .drs2 (bus.drs2),
        .luse (luse)
    );

    always_comb begin
        // Once in DWAIT only dack releases the stall; elsewhere a fresh pending access stalls.
        dstall  = (st == ST_DWAIT) ? ~bus.dack : (bus.dreq & ~bus.dack);
        // ireq is low only in the first cycle after reset, which also has no instruction.
        fwait   = ((st == ST_RUN) || (st == ST_IWAIT)) && (~ireq_q || ~bus.iack);
        // A branch re-seen inside FLUSH only reloads the counter, it is not a new entry.
        flu_ent = ~dstall && ((st == ST_DWAIT) ? (bpend | bus.xbra)
                                               : (bus.xbra && (st != ST_FLUSH)));
    end

    always_comb begin
        sena   = 1'b0;
        dbub   = 1'b0;
        dflush = 1'b0;
        if (srst) begin
            dflush = 1'b1;
        end else if (dstall) begin
            sena = 1'b0;
        end else if (st == ST_DWAIT) begin
            sena = 1'b1;
        end else if (st == ST_FLUSH) begin
            sena   = 1'b1;
            dbub   = 1'b1;
            dflush = 1'b1;
        end else if (fwait) begin
            sena = 1'b0;
        end else if (luse) begin
            // Execute and memory move on; decode holds and a NOP enters execute.
            sena = 1'b1;
            dbub = 1'b1;
        end else begin
            sena = 1'b1;
        end
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            st     <= ST_RUN;
            fcnt   <= 2'd0;
            ireq_q <= 1'b0;
            bpend  <= 1'b0;
            ihave  <= 1'b0;
        end else begin
            if (!dstall) begin
                ireq_q <= 1'b1;
            end
            if (dstall) begin
                st <= ST_DWAIT;
                if (st != ST_DWAIT) begin
                    // An interrupted flush is replayed in full after the access completes;
                    // fetch data landing during a flush is discarded, so it is not latched.
                    bpend <= bus.xbra | (st == ST_FLUSH);
                    ihave <= bus.iack & ireq_q & (st != ST_FLUSH);
                end else begin
                    bpend <= bpend | bus.xbra;
                    ihave <= ihave | bus.iack;
                end
            end else if (flu_ent) begin
                st    <= ST_FLUSH;
                fcnt  <= FCNT_LOAD;
                bpend <= 1'b0;
                ihave <= 1'b0;
            end else if (st == ST_DWAIT) begin
                // Fetch data latched during the stall means no return to IWAIT.
                st    <= (ihave | bus.iack) ? ST_RUN : ST_IWAIT;
                bpend <= 1'b0;
                ihave <= 1'b0;
            end else if (st == ST_FLUSH) begin
                if (bus.xbra) begin
                    fcnt <= FCNT_LOAD;
                end else if (fcnt == 2'd0) begin
                    st <= ST_RUN;
                end else begin
                    fcnt <= fcnt - 2'd1;
                end
            end else if (fwait) begin
                st <= ireq_q ? ST_IWAIT : ST_RUN;
            end else begin
                st <= ST_RUN;
            end
        end
    end

    assign bus.ireq   = ireq_q;
    assign bus.sena   = sena;
    assign bus.dbub   = dbub;
    assign bus.dflush = dflush;
    assign bus.sbusy  = ~sena;

`ifdef T5_PERFCNT_EN
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            cstl <= '0;
            cflu <= '0;
        end else begin
            if (!sena) begin
                cstl <= cstl + XLEN'(1);
            end
            if (flu_ent) begin
                cflu <= cflu + XLEN'(1);
            end
        end
    end
    // Decode opcode is not needed: the hazard check compares rs2 conservatively.
    logic unused_dopc;
    assign unused_dopc = &{1'b0, bus.dopc};
`else
    // Decode opcode is not needed: the hazard check compares rs2 conservatively.
    // XLEN only sizes the counters, which are absent in this build.
    localparam int unused_xlen = XLEN;
    logic unused_dopc;
    assign unused_dopc = &{1'b0, bus.dopc};
`endif

endmodule

// File: tb/tb_t5_pipe_ctrl.sv
// Bench for t5_pipe_ctrl: directed scenarios plus randomized traffic against a cycle-level
// reference model of the sequencing rules (stall / flush bookkeeping with plain counters).
module tb_t5_pipe_ctrl;

    localparam int XLEN      = 32;
    localparam int FLUSH_CYC = 2;

    logic sclk = 1'b0;
    logic srst = 1'b0;
    always #5 sclk = ~sclk;

    t5_pipe_ctrl_if bus();

`ifdef T5_PERFCNT_EN
    logic [XLEN-1:0] cstl;
    logic [XLEN-1:0] cflu;
`endif

    t5_pipe_ctrl #(.XLEN(XLEN), .FLUSH_CYC(FLUSH_CYC)) dut (
        .sclk (sclk),
        .srst (srst),
        .bus  (bus)
`ifdef T5_PERFCNT_EN
        ,
        .cstl (cstl),
        .cflu (cflu)
`endif
    );

    // Reference model state
    bit m_ireq;      // fetch request raised since reset
    bit m_dw;        // currently stalled on the data bus
    bit m_bpend;     // branch owed once the data stall ends
    int m_flush;     // flush cycles still to run (0 = not flushing)
    int m_stl;       // cycles with sena low
    int m_flu;       // flush entries

    int nchk  = 0;
    int npass = 0;

    // {ireq, sena, dbub, dflush, sbusy}
    logic [4:0] exp_o;
    logic [4:0] act_o;

    task automatic model_reset();
        m_ireq  = 1'b0;
        m_dw    = 1'b0;
        m_bpend = 1'b0;
        m_flush = 0;
        m_stl   = 0;
        m_flu   = 0;
    endtask

    task automatic set_idle();
        bus.iack = 1'b1;
        bus.dreq = 1'b0;
        bus.dack = 1'b0;
        bus.xbra = 1'b0;
        bus.dopc = 5'h04;
        bus.drs1 = 5'd0;
        bus.drs2 = 5'd0;
        bus.xopc = 5'h04;
        bus.xrd  = 5'd0;
    endtask

    // Computes this cycle's expected outputs from the model, samples the DUT at the
    // falling edge, then advances the model and the clock. Called at posedge+1.
    task automatic tick();
        bit sd, se, db, df, lu;
        lu = (bus.xopc == 5'h00) && (bus.xrd != 5'd0) &&
             ((bus.xrd == bus.drs1) || (bus.xrd == bus.drs2));
        sd = m_dw ? !bus.dack : (bus.dreq && !bus.dack);
        se = 1'b0; db = 1'b0; df = 1'b0;
        if (sd)                          se = 1'b0;
        else if (m_dw)                   se = 1'b1;
        else if (m_flush > 0)            begin se = 1'b1; db = 1'b1; df = 1'b1; end
        else if (!m_ireq || !bus.iack)   se = 1'b0;
        else                             begin se = 1'b1; db = lu; end
        exp_o = {m_ireq, se, db, df, !se};
        @(negedge sclk);
        act_o = {bus.ireq, bus.sena, bus.dbub, bus.dflush, bus.sbusy};
        if (!se) m_stl++;
        if (sd) begin
            m_bpend = m_dw ? (m_bpend || bus.xbra) : (bus.xbra || (m_flush > 0));
            m_dw    = 1'b1;
            m_flush = 0;
        end else begin
            m_ireq = 1'b1;
            if (m_dw) begin
                m_dw = 1'b0;
                if (m_bpend || bus.xbra) begin
                    m_flush = FLUSH_CYC;
                    m_flu++;
                end
                m_bpend = 1'b0;
            end else if (bus.xbra) begin
                if (m_flush == 0) m_flu++;
                m_flush = FLUSH_CYC;
            end else if (m_flush > 0) begin
                m_flush--;
            end
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        bus.iack = 1'b0;
        #2 srst = 1'b1;
        #1;
        act_o = {bus.ireq, bus.sena, bus.dbub, bus.dflush, bus.sbusy};
        nchk++;
        if (act_o !== 5'b00011) $display("FAIL reset_async {ireq,sena,dbub,dflush,sbusy} got %b exp %b", act_o, 5'b00011);
        else npass++;
        @(posedge sclk);
        #3;
        act_o = {bus.ireq, bus.sena, bus.dbub, bus.dflush, bus.sbusy};
        nchk++;
        if (act_o !== 5'b00011) $display("FAIL reset_held {ireq,sena,dbub,dflush,sbusy} got %b exp %b", act_o, 5'b00011);
        else npass++;
        srst = 1'b0;
        model_reset();
        #1;
        // cycle 0 has no request; iack arrives on the 3rd clock
        for (int i = 0; i < 4; i++) begin
            bus.iack = (i == 3);
            tick();
            nchk++;
            if (act_o !== exp_o) $display("FAIL reset_release c%0d got %b exp %b", i, act_o, exp_o);
            else npass++;
        end
    endtask

    task automatic test_dwait();
        int nz;
        set_idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            nchk++;
            if (act_o !== exp_o) $display("FAIL dwait_pre c%0d got %b exp %b", i, act_o, exp_o);
            else npass++;
        end
        nz = 0;
        bus.dreq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.dack = (i == 4);
            tick();
            if (act_o[3] == 1'b0) nz++;
            nchk++;
            if (act_o !== exp_o) $display("FAIL dwait c%0d got %b exp %b", i, act_o, exp_o);
            else npass++;
        end
        nchk++;
        if (nz != 4 || act_o[3] !== 1'b1) $display("FAIL dwait_len stall_cycles=%0d last_sena=%b exp 4 and 1", nz, act_o[3]);
        else npass++;
        set_idle();
    endtask

    task automatic test_flush();
        int nf;
        set_idle();
        nf = 0;
        for (int i = 0; i < 5; i++) begin
            bus.xbra = (i == 0);
            tick();
            if (act_o[2] && act_o[1]) nf++;
            nchk++;
            if (act_o !== exp_o) $display("FAIL flush c%0d got %b exp %b", i, act_o, exp_o);
            else npass++;
        end
        nchk++;
        if (nf != FLUSH_CYC || act_o[1] !== 1'b0) $display("FAIL flush_len flush_cycles=%0d last_dflush=%b exp %0d and 0", nf, act_o[1], FLUSH_CYC);
        else npass++;
`ifdef T5_PERFCNT_EN
        nchk++;
        if (cflu !== XLEN'(m_flu)) $display("FAIL flush_cflu got %0d exp %0d", cflu, m_flu);
        else npass++;
`endif
    endtask

    task automatic test_load_use();
        // {xopc, xrd, drs1, drs2, expected dbub}
        logic [20:0] tbl [4];
        tbl[0] = {5'h00, 5'd5, 5'd5, 5'd0, 1'b1};
        tbl[1] = {5'h00, 5'd0, 5'd0, 5'd0, 1'b0};
        tbl[2] = {5'h00, 5'd7, 5'd1, 5'd7, 1'b1};
        tbl[3] = {5'h04, 5'd5, 5'd5, 5'd5, 1'b0};
        set_idle();
        for (int i = 0; i < 4; i++) begin
            {bus.xopc, bus.xrd, bus.drs1, bus.drs2} = tbl[i][20:1];
            tick();
            nchk++;
            if (act_o !== exp_o || act_o[2] !== tbl[i][0])
                $display("FAIL load_use c%0d got %b exp %b (dbub exp %b)", i, act_o, exp_o, tbl[i][0]);
            else npass++;
        end
        set_idle();
    endtask

    task automatic test_branch_in_dwait();
        set_idle();
        bus.dreq = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.xbra = (i == 1);
            bus.dack = (i == 3);
            if (i > 3) bus.dreq = 1'b0;
            tick();
            nchk++;
            if (act_o !== exp_o) $display("FAIL branch_dwait c%0d got %b exp %b", i, act_o, exp_o);
            else npass++;
            // flush must begin only in the cycle after dack
            if (i == 4) begin
                nchk++;
                if (act_o[1] !== 1'b1) $display("FAIL branch_dwait_start dflush got %b exp 1", act_o[1]);
                else npass++;
            end
        end
        set_idle();
    endtask

    task automatic test_iack_dwait();
        set_idle();
        bus.dreq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.iack = (i == 0) || (i > 3);
            bus.dack = (i == 3);
            if (i > 3) bus.dreq = 1'b0;
            tick();
            nchk++;
            if (act_o !== exp_o) $display("FAIL iack_dwait c%0d got %b exp %b", i, act_o, exp_o);
            else npass++;
        end
`ifdef T5_PERFCNT_EN
        nchk++;
        if (cstl !== XLEN'(m_stl)) $display("FAIL iack_dwait_cstl got %0d exp %0d", cstl, m_stl);
        else npass++;
`endif
        set_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.iack = ($urandom_range(0, 9) < 7);
            bus.dreq = ($urandom_range(0, 9) < 3);
            bus.dack = ($urandom_range(0, 9) < 5);
            bus.xbra = ($urandom_range(0, 14) == 0);
            bus.dopc = 5'($urandom_range(0, 31));
            bus.xopc = ($urandom_range(0, 1) == 1) ? 5'h00 : 5'($urandom_range(0, 31));
            bus.xrd  = 5'($urandom_range(0, 3));
            bus.drs1 = 5'($urandom_range(0, 3));
            bus.drs2 = 5'($urandom_range(0, 3));
            tick();
            nchk++;
            if (act_o !== exp_o) $display("FAIL random c%0d got %b exp %b", i, act_o, exp_o);
            else npass++;
        end
`ifdef T5_PERFCNT_EN
        nchk++;
        if (cstl !== XLEN'(m_stl) || cflu !== XLEN'(m_flu))
            $display("FAIL random_cnt cstl=%0d cflu=%0d exp %0d %0d", cstl, cflu, m_stl, m_flu);
        else npass++;
`endif
        set_idle();
    endtask

    task automatic test_reset_mid_stall();
        set_idle();
        bus.dreq = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            nchk++;
            if (act_o !== exp_o) $display("FAIL midrst_pre c%0d got %b exp %b", i, act_o, exp_o);
            else npass++;
        end
        srst = 1'b1;
        #1;
        act_o = {bus.ireq, bus.sena, bus.dbub, bus.dflush, bus.sbusy};
        nchk++;
        if (act_o !== 5'b00011) $display("FAIL midrst_async got %b exp %b", act_o, 5'b00011);
        else npass++;
`ifdef T5_PERFCNT_EN
        nchk++;
        if (cstl !== '0 || cflu !== '0) $display("FAIL midrst_cnt cstl=%0d cflu=%0d exp 0 0", cstl, cflu);
        else npass++;
`endif
        #1 srst = 1'b0;
        model_reset();
        set_idle();
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            nchk++;
            if (act_o !== exp_o) $display("FAIL midrst_post c%0d got %b exp %b", i, act_o, exp_o);
            else npass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, passed %0d of %0d", npass, nchk);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        set_idle();
        test_reset();
        test_dwait();
        test_flush();
        test_load_use();
        test_branch_in_dwait();
        test_iack_dwait();
        test_random();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
